// File: rtl/div_cmd_issuer.sv
// div_cmd_issuer: queues tagged divide commands, issues them one at a time to
// divider_top, and returns tagged responses with a timeout watchdog and counters.
module div_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_mode_i,
  input  logic             cmd_out_type_i,
  input  logic [31:0]      cmd_n_i,
  input  logic [31:0]      cmd_d_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic             div_valid_o,
  output logic             div_mode_o,
  output logic             div_out_type_o,
  output logic [31:0]      div_n_o,
  output logic [31:0]      div_d_o,
  input  logic             div_ready_i,
  input  logic [31:0]      div_result_i,
  input  logic [1:0]       div_error_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [1:0]       rsp_error_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic [15:0]      ops_done_o,
  output logic [15:0]      err_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

  typedef struct packed {
    logic             mode;
    logic             out_type;
    logic [31:0]      n;
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DROP,
    WAIT_RESP,
    RESPOND
  } state_t;

  state_t           state;
  logic             primed;
  logic [TMR_W-1:0] timer;

  cmd_t             fifo_mem [FIFO_DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign cmd_in      = {cmd_mode_i, cmd_out_type_i, cmd_n_i, cmd_d_i, cmd_tag_i};
  assign head        = fifo_mem[rd_ptr];
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  // Before the first issue the divider has never raised ready, so don't wait for it.
  assign pop         = (state == IDLE) && !empty && (div_ready_i || !primed);
  assign busy_o      = (state != IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      primed         <= 1'b0;
      timer          <= '0;
      div_valid_o    <= 1'b0;
      div_mode_o     <= 1'b0;
      div_out_type_o <= 1'b0;
      div_n_o        <= '0;
      div_d_o        <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_result_o   <= '0;
      rsp_error_o    <= '0;
      rsp_tag_o      <= '0;
      ops_done_o     <= '0;
      err_cnt_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            div_mode_o     <= head.mode;
            div_out_type_o <= head.out_type;
            div_n_o        <= head.n;
            div_d_o        <= head.d;
            rsp_tag_o      <= head.tag;
            div_valid_o    <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          div_valid_o <= 1'b0;
          primed      <= 1'b1;
          timer       <= '0;
          state       <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (timer == TIMER_LAST) begin
            rsp_result_o <= '0;
            rsp_error_o  <= 2'b11;
            rsp_valid_o  <= 1'b1;
            primed       <= 1'b0;
            state        <= RESPOND;
          end else begin
            timer <= timer + 1'b1;
            if (!div_ready_i) begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          // A real answer arriving on the last watchdog cycle wins over the abort.
          if (div_ready_i) begin
            rsp_result_o <= div_result_i;
            rsp_error_o  <= div_error_i;
            rsp_valid_o  <= 1'b1;
            state        <= RESPOND;
          end else if (timer == TIMER_LAST) begin
            rsp_result_o <= '0;
            rsp_error_o  <= 2'b11;
            rsp_valid_o  <= 1'b1;
            primed       <= 1'b0;
            state        <= RESPOND;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            ops_done_o  <= ops_done_o + 16'd1;
            if (rsp_error_o != 2'b00) begin
              err_cnt_o <= err_cnt_o + 16'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_cmd_issuer.sv
// tb_div_cmd_issuer: directed table-driven checks of div_cmd_issuer against a
// behavioural divider stub, plus burst, timeout and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_div_cmd_issuer;

  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int TIMEOUT    = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic             cmd_out_type;
  logic [31:0]      cmd_n;
  logic [31:0]      cmd_d;
  logic [TAG_W-1:0] cmd_tag;
  logic             div_valid;
  logic             div_mode;
  logic             div_out_type;
  logic [31:0]      div_n;
  logic [31:0]      div_d;
  logic             div_ready;
  logic [31:0]      div_result;
  logic [1:0]       div_error;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [1:0]       rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [15:0]      ops_done;
  logic [15:0]      err_cnt;

  typedef struct {
    logic             mode;
    logic             out_type;
    logic [31:0]      n;
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
    logic             stuck;
    logic [31:0]      exp_result;
    logic [1:0]       exp_error;
  } vec_t;

  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   strobes    = 0;
  int   strobe_cyc = 0;
  int   rise_cyc   = 0;
  int   exp_ops    = 0;
  int   exp_errs   = 0;
  logic prev_ready = 1'b0;
  logic stub_stuck = 1'b0;

  int          stub_phase;
  int          stub_wait;
  logic        lat_mode;
  logic        lat_type;
  logic [31:0] lat_n;
  logic [31:0] lat_d;

  div_cmd_issuer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TAG_W     (TAG_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_mode_i    (cmd_mode),
    .cmd_out_type_i(cmd_out_type),
    .cmd_n_i       (cmd_n),
    .cmd_d_i       (cmd_d),
    .cmd_tag_i     (cmd_tag),
    .div_valid_o   (div_valid),
    .div_mode_o    (div_mode),
    .div_out_type_o(div_out_type),
    .div_n_o       (div_n),
    .div_d_o       (div_d),
    .div_ready_i   (div_ready),
    .div_result_i  (div_result),
    .div_error_i   (div_error),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_result_o  (rsp_result),
    .rsp_error_o   (rsp_error),
    .rsp_tag_o     (rsp_tag),
    .busy_o        (busy),
    .ops_done_o    (ops_done),
    .err_cnt_o     (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] ref_div(input logic mode, input logic qt,
                                          input logic [31:0] n, input logic [31:0] d);
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (d == 32'd0) return {2'b01, (qt ? 32'hFFFF_FFFF : n)};
    if (!mode && n == 32'h8000_0000 && d == 32'hFFFF_FFFF)
      return {2'b10, (qt ? 32'hFFFF_FFFF : 32'h0)};
    if (mode) return {2'b00, (qt ? (n / d) : (n % d))};
    sq = $signed(n) / $signed(d);
    sr = $signed(n) % $signed(d);
    return {2'b00, (qt ? sq : sr)};
  endfunction

  // Cycle counter plus strobe / ready-rise monitor, sampled on the pre-edge values.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_ready <= div_ready;
    if (div_valid) begin
      strobes    <= strobes + 1;
      strobe_cyc <= cyc;
    end
    if (div_ready && !prev_ready) begin
      rise_cyc <= cyc;
    end
  end

  // Divider stub: ready held one cycle after the strobe, operands latched a cycle late.
  always @(posedge clk) begin
    if (rst) begin
      div_ready  <= 1'b0;
      div_result <= '0;
      div_error  <= '0;
      stub_phase <= 0;
      stub_wait  <= 0;
    end else begin
      case (stub_phase)
        0: if (div_valid) stub_phase <= 1;
        1: begin
          lat_mode   <= div_mode;
          lat_type   <= div_out_type;
          lat_n      <= div_n;
          lat_d      <= div_d;
          div_ready  <= 1'b0;
          stub_wait  <= 3;
          stub_phase <= stub_stuck ? 0 : 2;
        end
        default: begin
          if (stub_wait == 0) begin
            {div_error, div_result} <= ref_div(lat_mode, lat_type, lat_n, lat_d);
            div_ready  <= 1'b1;
            stub_phase <= 0;
          end else begin
            stub_wait <= stub_wait - 1;
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportBound(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic applyStimulus(input vec_t v, output int push_cyc);
    stub_stuck   = v.stuck;
    cmd_valid    = 1'b1;
    cmd_mode     = v.mode;
    cmd_out_type = v.out_type;
    cmd_n        = v.n;
    cmd_d        = v.d;
    cmd_tag      = v.tag;
    for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clk);
    push_cyc = cyc;
    if (!cmd_ready) reportBound("cmd_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string name);
    int push_cyc;
    int rsp_cyc;
    int strobes0;
    int waited;
    strobes0 = strobes;
    applyStimulus(v, push_cyc);
    waited = 0;
    while (!rsp_valid && waited < TIMEOUT + 40) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      reportBound({name, " rsp_valid"});
      return;
    end
    rsp_cyc = cyc;
    checkOutput({name, " result"}, rsp_result, v.exp_result);
    checkOutput({name, " error"}, 32'(rsp_error), 32'(v.exp_error));
    checkOutput({name, " tag"}, 32'(rsp_tag), 32'(v.tag));
    checkOutput({name, " strobe count"}, strobes - strobes0, 1);
    checkOutput({name, " push-to-strobe"}, strobe_cyc - push_cyc, 2);
    if (v.stuck) checkOutput({name, " timeout latency"}, rsp_cyc - strobe_cyc, TIMEOUT + 1);
    else         checkOutput({name, " ready-to-rsp"}, rsp_cyc - rise_cyc, 1);
    repeat (2) @(negedge clk);
    checkOutput({name, " held valid"}, 32'(rsp_valid), 1);
    checkOutput({name, " held result"}, rsp_result, v.exp_result);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    if (v.exp_error != 2'b00) exp_errs++;
    checkOutput({name, " valid drop"}, 32'(rsp_valid), 0);
    checkOutput({name, " ops_done"}, 32'(ops_done), 32'(exp_ops[15:0]));
    checkOutput({name, " err_cnt"}, 32'(err_cnt), 32'(exp_errs[15:0]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    vec_t        tbl [9];
    vec_t        post;
    logic [31:0] burst_exp [6];
    int          accepts;
    int          got;
    int          full_at;
    int          rsp_seen;

    tbl[0] = '{1'b1, 1'b1, 32'd100,        32'd7,          4'h3, 1'b0, 32'd14,         2'b00};
    tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FF9C,  32'd7,          4'h5, 1'b0, 32'hFFFF_FFFE,  2'b00};
    tbl[2] = '{1'b1, 1'b0, 32'h1234,       32'd0,          4'h7, 1'b0, 32'h1234,       2'b01};
    tbl[3] = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  4'h9, 1'b0, 32'hFFFF_FFFF,  2'b10};
    tbl[4] = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,          4'hA, 1'b0, 32'hFFFF_FFF2,  2'b00};
    tbl[5] = '{1'b0, 1'b0, 32'd100,        32'hFFFF_FFF9,  4'h1, 1'b0, 32'd2,          2'b00};
    tbl[6] = '{1'b1, 1'b1, 32'hFFFF_FFFF,  32'd16,         4'hF, 1'b0, 32'h0FFF_FFFF,  2'b00};
    tbl[7] = '{1'b1, 1'b1, 32'd50,         32'd5,          4'hC, 1'b1, 32'd0,          2'b11};
    tbl[8] = '{1'b1, 1'b1, 32'd9,          32'd3,          4'h4, 1'b0, 32'd3,          2'b00};
    post   = '{1'b1, 1'b0, 32'd23,         32'd5,          4'h6, 1'b0, 32'd3,          2'b00};
    burst_exp = '{32'd0, 32'd3, 32'd7, 32'd10, 32'd13, 32'd17};

    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_mode     = 1'b0;
    cmd_out_type = 1'b0;
    cmd_n        = '0;
    cmd_d        = '0;
    cmd_tag      = '0;
    rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset div_valid", 32'(div_valid), 0);
    checkOutput("reset ops_done", 32'(ops_done), 0);
    checkOutput("reset err_cnt", 32'(err_cnt), 0);

    for (int i = 0; i < 9; i++) begin
      runVector(tbl[i], $sformatf("vec%0d", i));
    end

    // Burst of six with the response port stalled at first.
    accepts = 0;
    got     = 0;
    full_at = -1;
    for (int c = 0; c < 400 && got < 6; c++) begin
      if (c == 16) rsp_ready = 1'b1;
      if (accepts < 6) begin
        cmd_valid    = 1'b1;
        cmd_mode     = 1'b1;
        cmd_out_type = 1'b1;
        cmd_n        = 32'(10 * accepts + 1);
        cmd_d        = 32'd3;
        cmd_tag      = TAG_W'(accepts + 2);
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_valid && cmd_ready) accepts++;
      else if (cmd_valid && full_at < 0) full_at = accepts;
      if (rsp_valid && rsp_ready) begin
        checkOutput($sformatf("burst%0d tag", got), 32'(rsp_tag), 32'(got + 2));
        checkOutput($sformatf("burst%0d result", got), rsp_result, burst_exp[got]);
        got++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("burst accepts before full", full_at, FIFO_DEPTH + 1);
    if (got < 6) reportBound("burst responses");
    exp_ops += 6;
    checkOutput("burst ops_done", 32'(ops_done), 32'(exp_ops[15:0]));
    checkOutput("burst err_cnt", 32'(err_cnt), 32'(exp_errs[15:0]));

    // Reset while one command is in flight and another is queued.
    cmd_valid    = 1'b1;
    cmd_mode     = 1'b1;
    cmd_out_type = 1'b1;
    cmd_n        = 32'd77;
    cmd_d        = 32'd7;
    cmd_tag      = 4'h8;
    @(negedge clk);
    cmd_tag = 4'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midop busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midop reset cmd_ready", 32'(cmd_ready), 1);
    checkOutput("midop reset busy", 32'(busy), 0);
    checkOutput("midop reset div_valid", 32'(div_valid), 0);
    checkOutput("midop reset div_n", div_n, 0);
    checkOutput("midop reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("midop reset ops_done", 32'(ops_done), 0);
    checkOutput("midop reset err_cnt", 32'(err_cnt), 0);
    rst      = 1'b0;
    exp_ops  = 0;
    exp_errs = 0;
    rsp_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid || div_valid) rsp_seen++;
    end
    checkOutput("midop dropped activity", rsp_seen, 0);
    checkOutput("midop idle busy", 32'(busy), 0);

    runVector(post, "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
